// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants, state encoding and helpers for the receive payload extractor
package rx_pkg;

  localparam int          ETH_HDR_LEN  = 14;
  localparam int          ETH_FCS_LEN  = 4;
  localparam logic [15:0] ETHTYPE_VLAN = 16'h8100;
  localparam int          ETH_MIN_LEN  = 64;
  localparam int          VLAN_TAG_LEN = 4;

  localparam int ERR_SHORT    = 0;
  localparam int ERR_RUNT     = 1;
  localparam int ERR_OVERSIZE = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    VLAN,
    PAYLOAD,
    DISCARD
  } rx_state_t;

  function automatic logic [7:0] ascii_lower(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) ? (b + 8'h20) : b;
  endfunction

endpackage

// File: rtl/fcs_delay_line.sv
// rtl/fcs_delay_line.sv - hold-back shift register that keeps the trailing FCS bytes from being emitted
module fcs_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] in_data,
  output logic       full,
  output logic [7:0] out_data
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [CW-1:0] r_fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (flush) begin
      r_fill <= '0;
    end else if (push) begin
      r_mem[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      if (r_fill != FULL_CNT) r_fill <= r_fill + 1'b1;
    end
  end

  // Oldest byte leaves on the same push that brings the line past full.
  assign full     = (r_fill == FULL_CNT);
  assign out_data = r_mem[DEPTH-1];

endmodule

// File: rtl/rx_payload_extract.sv
// rtl/rx_payload_extract.sv - strips Ethernet header, optional VLAN tag and FCS from the GMAC rx stream
module rx_payload_extract
  import rx_pkg::*;
#(
  parameter int HDR_LEN  = ETH_HDR_LEN,
  parameter int FCS_LEN  = ETH_FCS_LEN,
  parameter bit VLAN_EN  = 1'b1,
  parameter bit LOWER_EN = 1'b1,
  parameter int MAX_LEN  = 1518
) (
  input  logic        rxcoreclk,
  input  logic        reset,
  input  logic [7:0]  gmac_rx_data,
  input  logic        gmac_rx_dvld,
  output logic [7:0]  pl_data,
  output logic        pl_dvld,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic [15:0] payload_len,
  output logic [2:0]  frame_err
);

  localparam logic [15:0] TYPE_MSB_IDX = 16'(HDR_LEN - 2);
  localparam logic [15:0] HDR_LAST_IDX = 16'(HDR_LEN - 1);
  localparam logic [15:0] TAG_LAST_IDX = 16'(HDR_LEN + VLAN_TAG_LEN - 1);
  localparam logic [15:0] MAX_CNT      = 16'(MAX_LEN);
  localparam logic [15:0] MIN_CNT      = 16'(ETH_MIN_LEN);

  rx_state_t   r_state, w_next_state;
  logic        r_after_rst;
  logic [15:0] r_cnt;
  logic [15:0] r_pl_cnt;
  logic        r_over;
  logic [7:0]  r_type_msb;
  logic [7:0]  r_pl_data;
  logic        r_pl_dvld;
  logic        r_frame_done;
  logic [15:0] r_frame_len;
  logic [15:0] r_payload_len;
  logic [2:0]  r_frame_err;

  logic        w_active, w_end, w_push, w_full, w_byte_over, w_emit;
  logic [7:0]  w_dl_out, w_out_byte;
  logic [2:0]  w_err;

  assign w_active    = (r_state == HDR) || (r_state == VLAN) || (r_state == PAYLOAD);
  assign w_end       = w_active && !gmac_rx_dvld;
  assign w_push      = (r_state == PAYLOAD) && gmac_rx_dvld;
  assign w_byte_over = gmac_rx_dvld && (r_cnt >= MAX_CNT);
  assign w_emit      = w_push && w_full && !r_over && !w_byte_over;
  assign w_out_byte  = LOWER_EN ? ascii_lower(w_dl_out) : w_dl_out;

  fcs_delay_line #(
    .DEPTH (FCS_LEN)
  ) u_fcs_delay_line (
    .clk      (rxcoreclk),
    .reset    (reset),
    .push     (w_push),
    .flush    (w_end),
    .in_data  (gmac_rx_data),
    .full     (w_full),
    .out_data (w_dl_out)
  );

  always_comb begin
    w_err               = '0;
    w_err[ERR_OVERSIZE] = r_over;
    w_err[ERR_RUNT]     = (r_cnt < MIN_CNT);
    w_err[ERR_SHORT]    = (r_pl_cnt == 16'd0);
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        // A frame already in flight when reset releases has no usable header.
        if (gmac_rx_dvld) w_next_state = r_after_rst ? DISCARD : HDR;
      end
      HDR: begin
        if (!gmac_rx_dvld) begin
          w_next_state = IDLE;
        end else if (r_cnt == HDR_LAST_IDX) begin
          w_next_state = (VLAN_EN && ({r_type_msb, gmac_rx_data} == ETHTYPE_VLAN)) ? VLAN : PAYLOAD;
        end
      end
      VLAN: begin
        if (!gmac_rx_dvld)                 w_next_state = IDLE;
        else if (r_cnt == TAG_LAST_IDX)    w_next_state = PAYLOAD;
      end
      PAYLOAD: begin
        if (!gmac_rx_dvld) w_next_state = IDLE;
      end
      DISCARD: begin
        if (!gmac_rx_dvld) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_after_rst   <= 1'b1;
      r_cnt         <= 16'd0;
      r_pl_cnt      <= 16'd0;
      r_over        <= 1'b0;
      r_type_msb    <= 8'h00;
      r_pl_data     <= 8'h00;
      r_pl_dvld     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_len   <= 16'd0;
      r_payload_len <= 16'd0;
      r_frame_err   <= 3'b000;
    end else begin
      r_state      <= w_next_state;
      r_after_rst  <= 1'b0;
      r_frame_done <= w_end;
      r_pl_dvld    <= w_emit;
      r_pl_data    <= w_emit ? w_out_byte : 8'h00;

      if (r_state == IDLE) begin
        r_cnt    <= gmac_rx_dvld ? 16'd1 : 16'd0;
        r_pl_cnt <= 16'd0;
        r_over   <= 1'b0;
      end else if (w_active && gmac_rx_dvld) begin
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (w_byte_over)       r_over <= 1'b1;
        if (w_emit)            r_pl_cnt <= r_pl_cnt + 16'd1;
      end

      if ((r_state == HDR) && gmac_rx_dvld && (r_cnt == TYPE_MSB_IDX)) r_type_msb <= gmac_rx_data;

      if (w_end) begin
        r_frame_len   <= r_cnt;
        r_payload_len <= r_pl_cnt;
        r_frame_err   <= w_err;
      end
    end
  end

  assign pl_data     = r_pl_data;
  assign pl_dvld     = r_pl_dvld;
  assign frame_done  = r_frame_done;
  assign frame_len   = r_frame_len;
  assign payload_len = r_payload_len;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_rx_payload_extract.sv
// tb/tb_rx_payload_extract.sv - randomized frame bench against a byte-level reference model
module tb_rx_payload_extract;

  localparam int HDR_LEN = 14;
  localparam int FCS_LEN = 4;
  localparam int MAX_LEN = 1518;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       dvld  = 1'b0;

  logic [7:0]  pl_data_v, pl_data_n;
  logic        pl_dvld_v, pl_dvld_n, frame_done_v, frame_done_n;
  logic [15:0] frame_len_v, frame_len_n, payload_len_v, payload_len_n;
  logic [2:0]  frame_err_v, frame_err_n;

  rx_payload_extract #(.VLAN_EN(1'b1), .LOWER_EN(1'b1)) dut_v (
    .rxcoreclk(clk), .reset(reset), .gmac_rx_data(din), .gmac_rx_dvld(dvld),
    .pl_data(pl_data_v), .pl_dvld(pl_dvld_v), .frame_done(frame_done_v),
    .frame_len(frame_len_v), .payload_len(payload_len_v), .frame_err(frame_err_v)
  );

  rx_payload_extract #(.VLAN_EN(1'b0), .LOWER_EN(1'b0)) dut_n (
    .rxcoreclk(clk), .reset(reset), .gmac_rx_data(din), .gmac_rx_dvld(dvld),
    .pl_data(pl_data_n), .pl_dvld(pl_dvld_n), .frame_done(frame_done_n),
    .frame_len(frame_len_n), .payload_len(payload_len_n), .frame_err(frame_err_n)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  fr[$];
  logic [7:0]  exp_bv[$], exp_bn[$], got_bv[$], got_bn[$];
  logic [34:0] exp_sv[$], exp_sn[$], got_sv[$], got_sn[$];
  int exp_burst_v = 0, exp_burst_n = 0;
  int burst_v = 0, burst_n = 0, overlap_v = 0, overlap_n = 0;
  bit prev_v = 1'b0, prev_n = 1'b0;
  int clr_gen = 0, seen_gen = 0;

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      got_bv.delete(); got_bn.delete(); got_sv.delete(); got_sn.delete();
      burst_v = 0; burst_n = 0; overlap_v = 0; overlap_n = 0;
      prev_v = 1'b0; prev_n = 1'b0;
      seen_gen = clr_gen;
    end
    if (pl_dvld_v) got_bv.push_back(pl_data_v);
    if (pl_dvld_v && !prev_v) burst_v++;
    if (pl_dvld_v && frame_done_v) overlap_v++;
    if (frame_done_v) got_sv.push_back({frame_len_v, payload_len_v, frame_err_v});
    prev_v = pl_dvld_v;
    if (pl_dvld_n) got_bn.push_back(pl_data_n);
    if (pl_dvld_n && !prev_n) burst_n++;
    if (pl_dvld_n && frame_done_n) overlap_n++;
    if (frame_done_n) got_sn.push_back({frame_len_n, payload_len_n, frame_err_n});
    prev_n = pl_dvld_n;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output of one frame from the frame rules: header (+tag) and FCS removed,
  // nothing emitted whose push would be beyond MAX_LEN, optional case fold.
  task automatic model(input bit vlan_inst);
    int len, first, last, npl;
    logic [7:0]  b;
    logic [15:0] flen;
    logic [2:0]  err;
    len   = fr.size();
    first = HDR_LEN;
    npl   = 0;
    if (vlan_inst && len >= HDR_LEN && fr[HDR_LEN-2] == 8'h81 && fr[HDR_LEN-1] == 8'h00)
      first = HDR_LEN + 4;
    last = len - FCS_LEN - 1;
    if (last > MAX_LEN - FCS_LEN - 1) last = MAX_LEN - FCS_LEN - 1;
    for (int i = first; i <= last; i++) begin
      b = fr[i];
      if (vlan_inst && b >= 8'h41 && b <= 8'h5A) b = b + 8'h20;
      if (vlan_inst) exp_bv.push_back(b); else exp_bn.push_back(b);
      npl++;
    end
    flen = (len > 65535) ? 16'hFFFF : 16'(len);
    err  = {len > MAX_LEN, len < 64, npl == 0};
    if (vlan_inst) begin
      exp_sv.push_back({flen, 16'(npl), err});
      if (npl > 0) exp_burst_v++;
    end else begin
      exp_sn.push_back({flen, 16'(npl), err});
      if (npl > 0) exp_burst_n++;
    end
  endtask

  task automatic build_frame(input int len, input logic [15:0] etype);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
    if (len >= HDR_LEN) begin
      fr[HDR_LEN-2] = etype[15:8];
      fr[HDR_LEN-1] = etype[7:0];
    end
    if (etype == 16'h8100 && len >= HDR_LEN + 4) begin
      fr[HDR_LEN+2] = 8'h08;
      fr[HDR_LEN+3] = 8'h00;
    end
  endtask

  task automatic send_frame(input int gap);
    model(1'b1);
    model(1'b0);
    foreach (fr[i]) begin
      @(negedge clk);
      din  = fr[i];
      dvld = 1'b1;
    end
    @(negedge clk);
    dvld = 1'b0;
    din  = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_batch(input string tag);
    int mis;
    repeat (8) @(negedge clk);
    check_eq({tag, " done_v"}, got_sv.size(), exp_sv.size());
    for (int i = 0; i < exp_sv.size() && i < got_sv.size(); i++)
      check_eq({tag, " status_v"}, got_sv[i], exp_sv[i]);
    check_eq({tag, " nbytes_v"}, got_bv.size(), exp_bv.size());
    mis = 0;
    for (int i = 0; i < exp_bv.size() && i < got_bv.size(); i++) if (got_bv[i] !== exp_bv[i]) mis++;
    check_eq({tag, " bytes_v"}, mis, 0);
    check_eq({tag, " bursts_v"}, burst_v, exp_burst_v);
    check_eq({tag, " overlap_v"}, overlap_v, 0);
    check_eq({tag, " done_n"}, got_sn.size(), exp_sn.size());
    for (int i = 0; i < exp_sn.size() && i < got_sn.size(); i++)
      check_eq({tag, " status_n"}, got_sn[i], exp_sn[i]);
    check_eq({tag, " nbytes_n"}, got_bn.size(), exp_bn.size());
    mis = 0;
    for (int i = 0; i < exp_bn.size() && i < got_bn.size(); i++) if (got_bn[i] !== exp_bn[i]) mis++;
    check_eq({tag, " bytes_n"}, mis, 0);
    check_eq({tag, " bursts_n"}, burst_n, exp_burst_n);
    check_eq({tag, " overlap_n"}, overlap_n, 0);
    exp_bv.delete(); exp_bn.delete(); exp_sv.delete(); exp_sn.delete();
    exp_burst_v = 0;
    exp_burst_n = 0;
    clr_gen++;
    @(negedge clk);
  endtask

  initial begin
    string s;
    logic [15:0] et;

    repeat (3) @(negedge clk);
    check_eq("rst pl_dvld", pl_dvld_v, 1'b0);
    check_eq("rst frame_done", frame_done_v, 1'b0);
    check_eq("rst frame_len", frame_len_v, 16'd0);
    check_eq("rst payload_len", payload_len_n, 16'd0);
    check_eq("rst frame_err", frame_err_v, 3'b000);
    check_eq("rst pl_data", pl_data_v, 8'h00);
    reset = 1'b0;
    clr_gen++;
    @(negedge clk);

    s = "HeLLo hers";
    build_frame(64, 16'h0800);
    for (int i = 0; i < 46; i++) fr[HDR_LEN+i] = (i < s.len()) ? s[i] : 8'h00;
    send_frame(3);
    check_batch("eth64");

    build_frame(64, 16'h8100);
    for (int i = 0; i < 42; i++) fr[HDR_LEN+4+i] = (i < s.len()) ? s[i] : 8'h00;
    send_frame(3);
    check_batch("vlan64");

    build_frame(20, 16'h8100);
    send_frame(3);
    check_batch("runt20");

    build_frame(1600, 16'h0800);
    send_frame(3);
    check_batch("over1600");

    build_frame(64, 16'h0800);
    send_frame(1);
    build_frame(64, 16'h8100);
    send_frame(3);
    check_batch("b2b");

    build_frame(64, 16'h0800);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      din  = fr[i];
      dvld = 1'b1;
    end
    @(negedge clk);
    din   = fr[30];
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst pl_dvld", pl_dvld_v, 1'b0);
    check_eq("midrst frame_done", frame_done_v, 1'b0);
    check_eq("midrst frame_len", frame_len_v, 16'd0);
    clr_gen++;
    @(negedge clk);
    reset = 1'b0;
    din   = fr[31];
    for (int i = 32; i < 50; i++) begin
      @(negedge clk);
      din = fr[i];
    end
    @(negedge clk);
    dvld = 1'b0;
    check_batch("midrst_abort");

    build_frame(70, 16'h0800);
    send_frame(2);
    check_batch("post_rst");

    for (int b = 0; b < 3; b++) begin
      for (int f = 0; f < 6; f++) begin
        case ($urandom_range(0, 3))
          0:       et = 16'h8100;
          1:       et = 16'h8101;
          2:       et = 16'h0081;
          default: et = 16'h0800;
        endcase
        build_frame(int'($urandom_range(24, 200)), et);
        send_frame(int'($urandom_range(1, 3)));
      end
      check_batch("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
